// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle controller: opcode values, FSM state
// encodings, PC source selects and the opcode-class bundle.
package multicycle_control_pkg;

  localparam int OP_R    = 0;
  localparam int OP_J    = 1;
  localparam int OP_BNE  = 2;
  localparam int OP_ADDI = 5;
  localparam int OP_SW   = 7;
  localparam int OP_LW   = 8;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_e;

  localparam logic [1:0] PCSEL_INC = 2'd0;
  localparam logic [1:0] PCSEL_BR  = 2'd1;
  localparam logic [1:0] PCSEL_JMP = 2'd2;

  typedef struct packed {
    logic is_r;
    logic is_j;
    logic is_bne;
    logic is_addi;
    logic is_sw;
    logic is_lw;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/multicycle_control_opcode_class_decode.sv
// Combinational opcode classifier; branch opcodes fold into illegal when
// branch support is disabled.
module opcode_class_decode
  import multicycle_control_pkg::*;
#(
  parameter int OPW       = 5,
  parameter bit EN_BRANCH = 1'b1
) (
  input  logic [OPW-1:0] i_opcode,
  output op_class_t      o_class
);

  always_comb begin
    o_class         = '0;
    o_class.is_r    = (i_opcode == OPW'(OP_R));
    o_class.is_j    = EN_BRANCH && (i_opcode == OPW'(OP_J));
    o_class.is_bne  = EN_BRANCH && (i_opcode == OPW'(OP_BNE));
    o_class.is_addi = (i_opcode == OPW'(OP_ADDI));
    o_class.is_sw   = (i_opcode == OPW'(OP_SW));
    o_class.is_lw   = (i_opcode == OPW'(OP_LW));
    o_class.illegal = ~(o_class.is_r | o_class.is_j | o_class.is_bne |
                        o_class.is_addi | o_class.is_sw | o_class.is_lw);
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with per-state
// control strobes, memory-timeout and illegal-opcode trap, and a retire counter.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OPW         = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNTW        = 32,
  parameter bit EN_BRANCH   = 1'b1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [OPW-1:0]  opcode,
  input  logic            imem_valid,
  input  logic            dmem_ready,
  input  logic            alu_ne,
  output logic            imem_req,
  output logic            ir_we,
  output logic            pc_we,
  output logic [1:0]      pc_sel,
  output logic            dmem_req,
  output logic            DMwe,
  output logic            ALUinB,
  output logic            Rwe,
  output logic            Rdst,
  output logic            Rwd,
  output logic [2:0]      state,
  output logic            trap,
  output logic [CNTW-1:0] retired
);

  localparam int WCW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_e          r_state;
  state_e          w_next;
  logic [OPW-1:0]  r_opcode;
  logic [WCW-1:0]  r_wait;
  logic            r_trap;
  logic [CNTW-1:0] r_retired;

  op_class_t  w_cls;
  logic       w_imem_req, w_ir_we, w_pc_we, w_dmem_req, w_dmwe;
  logic       w_aluinb, w_rwe, w_rdst, w_rwd;
  logic [1:0] w_pc_sel;
  logic       w_load_op, w_clr_wait, w_inc_wait, w_set_trap, w_retire;

  opcode_class_decode #(
    .OPW       (OPW),
    .EN_BRANCH (EN_BRANCH)
  ) u_decode (
    .i_opcode (r_opcode),
    .o_class  (w_cls)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_FETCH;
      r_opcode  <= '0;
      r_wait    <= '0;
      r_trap    <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_load_op) r_opcode <= opcode;
      if (w_clr_wait)      r_wait <= '0;
      else if (w_inc_wait) r_wait <= r_wait + WCW'(1);
      if (w_set_trap) r_trap <= 1'b1;
      if (w_retire)   r_retired <= r_retired + CNTW'(1);
    end
  end

  always_comb begin
    w_next     = r_state;
    w_imem_req = 1'b0;
    w_ir_we    = 1'b0;
    w_pc_we    = 1'b0;
    w_pc_sel   = PCSEL_INC;
    w_dmem_req = 1'b0;
    w_dmwe     = 1'b0;
    w_aluinb   = 1'b0;
    w_rwe      = 1'b0;
    w_rdst     = 1'b0;
    w_rwd      = 1'b0;
    w_load_op  = 1'b0;
    w_clr_wait = 1'b0;
    w_inc_wait = 1'b0;
    w_set_trap = 1'b0;
    w_retire   = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_imem_req = 1'b1;
        if (imem_valid) begin
          w_ir_we   = 1'b1;
          w_pc_we   = 1'b1;
          w_load_op = 1'b1;
          w_next    = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (w_cls.illegal) begin
          w_set_trap = 1'b1;
          w_next     = ST_TRAP;
        end else if (w_cls.is_j) begin
          w_pc_we  = 1'b1;
          w_pc_sel = PCSEL_JMP;
          w_retire = 1'b1;
          w_next   = ST_FETCH;
        end else begin
          w_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_aluinb = w_cls.is_addi | w_cls.is_lw | w_cls.is_sw;
        if (w_cls.is_bne) begin
          w_pc_we  = alu_ne;
          w_pc_sel = PCSEL_BR;
          w_retire = 1'b1;
          w_next   = ST_FETCH;
        end else if (w_cls.is_sw | w_cls.is_lw) begin
          w_clr_wait = 1'b1;
          w_next     = ST_MEM;
        end else begin
          w_next = ST_WB;
        end
      end
      ST_MEM: begin
        w_dmem_req = 1'b1;
        w_dmwe     = w_cls.is_sw;
        w_aluinb   = 1'b1;
        // A ready arriving on the final allowed cycle still completes the access.
        if (dmem_ready) begin
          if (w_cls.is_sw) begin
            w_retire = 1'b1;
            w_next   = ST_FETCH;
          end else begin
            w_next = ST_WB;
          end
        end else if (r_wait == WCW'(MEM_TIMEOUT - 1)) begin
          w_set_trap = 1'b1;
          w_next     = ST_TRAP;
        end else begin
          w_inc_wait = 1'b1;
        end
      end
      ST_WB: begin
        w_rwe    = 1'b1;
        w_rdst   = w_cls.is_r;
        w_rwd    = w_cls.is_lw;
        w_aluinb = w_cls.is_addi | w_cls.is_lw;
        w_retire = 1'b1;
        w_next   = ST_FETCH;
      end
      ST_TRAP: w_next = ST_TRAP;
      default: begin
        w_set_trap = 1'b1;
        w_next     = ST_TRAP;
      end
    endcase
  end

  // Strobes are forced low combinationally while reset is held.
  assign imem_req = reset_n & w_imem_req;
  assign ir_we    = reset_n & w_ir_we;
  assign pc_we    = reset_n & w_pc_we;
  assign pc_sel   = reset_n ? w_pc_sel : 2'd0;
  assign dmem_req = reset_n & w_dmem_req;
  assign DMwe     = reset_n & w_dmwe;
  assign ALUinB   = reset_n & w_aluinb;
  assign Rwe      = reset_n & w_rwe;
  assign Rdst     = reset_n & w_rdst;
  assign Rwd      = reset_n & w_rwd;
  assign state    = r_state;
  assign trap     = r_trap;
  assign retired  = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected control vectors are
// queued when an instruction is issued and compared as the DUT steps through it.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  localparam int MT = 15;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [4:0] opcode;
  logic       imem_valid, dmem_ready, alu_ne;

  logic        m_imem_req, m_ir_we, m_pc_we, m_dmem_req, m_DMwe, m_ALUinB;
  logic        m_Rwe, m_Rdst, m_Rwd, m_trap;
  logic [1:0]  m_pc_sel;
  logic [2:0]  m_state;
  logic [31:0] m_retired;

  logic        n_imem_req, n_ir_we, n_pc_we, n_dmem_req, n_DMwe, n_ALUinB;
  logic        n_Rwe, n_Rdst, n_Rwd, n_trap;
  logic [1:0]  n_pc_sel;
  logic [2:0]  n_state;
  logic [1:0]  n_retired;

  logic [14:0] exp_q[$];
  logic [1:0]  stim_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] exp_ret;
  logic        sel;
  logic [4:0]  cur_op;
  logic        cur_ane;
  logic [14:0] m_vec, n_vec, obs;
  int          ops[6] = '{0, 1, 2, 5, 7, 8};

  always #5 clock = ~clock;

  multicycle_control #(.OPW(5), .MEM_TIMEOUT(MT), .CNTW(32), .EN_BRANCH(1'b1)) dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .imem_valid(imem_valid),
    .dmem_ready(dmem_ready), .alu_ne(alu_ne), .imem_req(m_imem_req), .ir_we(m_ir_we),
    .pc_we(m_pc_we), .pc_sel(m_pc_sel), .dmem_req(m_dmem_req), .DMwe(m_DMwe),
    .ALUinB(m_ALUinB), .Rwe(m_Rwe), .Rdst(m_Rdst), .Rwd(m_Rwd), .state(m_state),
    .trap(m_trap), .retired(m_retired)
  );

  multicycle_control #(.OPW(5), .MEM_TIMEOUT(MT), .CNTW(2), .EN_BRANCH(1'b0)) dut_nb (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .imem_valid(imem_valid),
    .dmem_ready(dmem_ready), .alu_ne(alu_ne), .imem_req(n_imem_req), .ir_we(n_ir_we),
    .pc_we(n_pc_we), .pc_sel(n_pc_sel), .dmem_req(n_dmem_req), .DMwe(n_DMwe),
    .ALUinB(n_ALUinB), .Rwe(n_Rwe), .Rdst(n_Rdst), .Rwd(n_Rwd), .state(n_state),
    .trap(n_trap), .retired(n_retired)
  );

  assign m_vec = {m_state, m_imem_req, m_ir_we, m_pc_we, m_pc_sel, m_dmem_req, m_DMwe,
                  m_ALUinB, m_Rwe, m_Rdst, m_Rwd, m_trap};
  assign n_vec = {n_state, n_imem_req, n_ir_we, n_pc_we, n_pc_sel, n_dmem_req, n_DMwe,
                  n_ALUinB, n_Rwe, n_Rdst, n_Rwd, n_trap};
  assign obs = sel ? n_vec : m_vec;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  function automatic logic [14:0] pk(input logic [2:0] st, input logic ireq, input logic irwe,
                                     input logic pcwe, input logic [1:0] psel, input logic dreq,
                                     input logic dmwe, input logic alub, input logic rwe,
                                     input logic rdst, input logic rwd, input logic trp);
    return {st, ireq, irwe, pcwe, psel, dreq, dmwe, alub, rwe, rdst, rwd, trp};
  endfunction

  task automatic push(input logic [14:0] e, input logic iv, input logic dr);
    exp_q.push_back(e);
    stim_q.push_back({iv, dr});
  endtask

  task automatic push_trap(input int n);
    for (int i = 0; i < n; i++) push(pk(3'd7, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1), 1'b1, 1'b1);
  endtask

  // Expected per-cycle trace of one instruction, written from the state/strobe table.
  task automatic push_instr(input logic [4:0] op, input int fstall, input int waits,
                            input logic rdy, input logic ane);
    logic en, r, j, bne, addi, sw, lw, done;
    en = ~sel;
    cur_op = op;
    cur_ane = ane;
    r = (op == 5'd0); j = en && (op == 5'd1); bne = en && (op == 5'd2);
    addi = (op == 5'd5); sw = (op == 5'd7); lw = (op == 5'd8);
    for (int i = 0; i < fstall; i++) push(pk(3'd0, 1, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    push(pk(3'd0, 1, 1, 1, 2'd0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0);
    if (!(r | j | bne | addi | sw | lw)) begin
      push(pk(3'd1, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
      push_trap(1);
      return;
    end
    if (j) begin
      push(pk(3'd1, 0, 0, 1, 2'd2, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
      exp_ret = exp_ret + 1;
      return;
    end
    push(pk(3'd1, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    if (bne) begin
      push(pk(3'd2, 0, 0, ane, 2'd1, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
      exp_ret = exp_ret + 1;
      return;
    end
    push(pk(3'd2, 0, 0, 0, 2'd0, 0, 0, addi | sw | lw, 0, 0, 0, 0), 1'b0, 1'b0);
    if (sw | lw) begin
      done = 1'b0;
      for (int k = 0; k < MT; k++) begin
        if (rdy && k == waits) begin
          push(pk(3'd3, 0, 0, 0, 2'd0, 1, sw, 1, 0, 0, 0, 0), 1'b0, 1'b1);
          done = 1'b1;
          break;
        end
        push(pk(3'd3, 0, 0, 0, 2'd0, 1, sw, 1, 0, 0, 0, 0), 1'b0, 1'b0);
      end
      if (!done) begin
        push_trap(1);
        return;
      end
      if (sw) begin
        exp_ret = exp_ret + 1;
        return;
      end
    end
    push(pk(3'd4, 0, 0, 0, 2'd0, 0, 0, addi | lw, 1, r, lw, 0), 1'b0, 1'b0);
    exp_ret = exp_ret + 1;
  endtask

  task automatic run_q(input int max_cyc, input string tag);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < max_cyc) begin
      {imem_valid, dmem_ready} = stim_q.pop_front();
      opcode = cur_op;
      alu_ne = cur_ane;
      @(negedge clock);
      chk($sformatf("%s@%0d", tag, n), {17'd0, obs}, {17'd0, exp_q.pop_front()});
      @(posedge clock);
      #1;
      n++;
    end
    exp_q.delete();
    stim_q.delete();
    imem_valid = 1'b0;
    dmem_ready = 1'b0;
  endtask

  task automatic chk_ret(input string tag);
    chk(tag, sel ? {30'd0, n_retired} : m_retired, sel ? (exp_ret & 32'd3) : exp_ret);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    imem_valid = 1'b0;
    dmem_ready = 1'b0;
    exp_ret = 0;
    #1;
    chk({tag, "_vec"}, {17'd0, obs}, {17'd0, pk(3'd0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0)});
    chk_ret({tag, "_ret"});
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; opcode = '0; imem_valid = 1'b0; dmem_ready = 1'b0; alu_ne = 1'b0;
    sel = 1'b0; exp_ret = 0; cur_op = '0; cur_ane = 1'b0;
    @(posedge clock);
    #1;
    do_reset("rst0");

    push_instr(5'(OP_ADDI), 0, 0, 1'b0, 1'b0); run_q(100, "addi"); chk_ret("addi_ret");
    push_instr(5'(OP_R), 2, 0, 1'b0, 1'b0);    run_q(100, "rtype"); chk_ret("r_ret");
    push_instr(5'(OP_LW), 0, 3, 1'b1, 1'b0);   run_q(100, "lw3"); chk_ret("lw_ret");
    push_instr(5'(OP_SW), 0, 0, 1'b1, 1'b0);   run_q(100, "sw0"); chk_ret("sw_ret");
    push_instr(5'(OP_BNE), 0, 0, 1'b0, 1'b1);  run_q(100, "bne1");
    push_instr(5'(OP_BNE), 1, 0, 1'b0, 1'b0);  run_q(100, "bne0");
    push_instr(5'(OP_J), 0, 0, 1'b0, 1'b0);    run_q(100, "jmp"); chk_ret("br_ret");
    push_instr(5'(OP_SW), 0, MT - 1, 1'b1, 1'b0); run_q(100, "sw_edge"); chk_ret("edge_ret");

    for (int i = 0; i < 12; i++) begin
      push_instr(5'(ops[$urandom_range(0, 5)]), $urandom_range(0, 2), $urandom_range(0, 5),
                 1'b1, 1'($urandom_range(0, 1)));
      run_q(100, $sformatf("rnd%0d", i));
      chk_ret($sformatf("rnd%0d_ret", i));
    end

    push_instr(5'(OP_LW), 0, 0, 1'b0, 1'b0);
    run_q(5, "lw_abort");
    chk("abort_dreq", {31'd0, m_dmem_req}, 32'd1);
    do_reset("rst_mid");

    push_instr(5'(OP_SW), 0, 0, 1'b0, 1'b0);
    push_trap(3);
    run_q(100, "sw_timeout");
    chk_ret("timeout_ret");
    do_reset("rst_to");

    push_instr(5'd31, 0, 0, 1'b0, 1'b0);
    push_trap(2);
    run_q(100, "illegal");
    chk_ret("illegal_ret");
    do_reset("rst_ill");

    sel = 1'b1;
    do_reset("nb_rst");
    for (int i = 0; i < 3; i++) begin
      push_instr(5'(OP_R), 0, 0, 1'b0, 1'b0);
      run_q(100, $sformatf("nb_r%0d", i));
    end
    chk_ret("nb_full");
    push_instr(5'(OP_R), 0, 0, 1'b0, 1'b0); run_q(100, "nb_wrap"); chk_ret("nb_wrap_ret");
    push_instr(5'(OP_BNE), 0, 0, 1'b0, 1'b1); run_q(100, "nb_bne");
    do_reset("nb_rst2");
    push_instr(5'(OP_J), 0, 0, 1'b0, 1'b0); run_q(100, "nb_j");
    do_reset("nb_rst3");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
